// File: rtl/encoder4to2_reg.sv
`default_nettype none
// ============================================================================
//  Module      : encoder4to2_reg
//  Description : Registered 4-to-2 priority encoder with a valid/ready
//                handshake. Returns the index of the highest active line,
//                an any-active flag, a multi-hot flag and a saturating
//                count of accepted multi-hot results.
//
//  Ports
//    clk        in   1      rising-edge clock
//    rst        in   1      asynchronous active-high reset
//    E          in   1      enable, sampled with D on accept
//    D          in   4      input lines, D[3] highest priority
//    in_valid   in   1      D/E valid this cycle
//    in_ready   out  1      block can accept this cycle
//    Y          out  2      index of highest set bit of D
//    V          out  1      at least one line set (and E=1)
//    M          out  1      more than one line set (and E=1)
//    out_valid  out  1      Y/V/M hold a result
//    out_ready  in   1      consumer takes the result this cycle
//    err_clr    in   1      synchronous clear of err_count
//    err_count  out  CNT_W  accepted multi-hot results, saturating
//
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder4to2_reg #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic [3:0]       D,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       Y,
    output logic             V,
    output logic             M,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       r_y;
    logic             r_v;
    logic             r_m;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_err_count;

    logic             w_accept;
    logic             w_drain;
    logic [1:0]       w_y;
    logic             w_v;
    logic             w_m;

    // A slot frees up either when empty or when the consumer drains it in
    // the same cycle; this is what allows back-to-back results.
    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_out_valid & out_ready;

    // Priority encode; a disabled input always encodes to the all-zero result.
    always_comb begin
        w_y = 2'd0;
        w_v = 1'b0;
        w_m = 1'b0;
        if (E) begin
            if (D[3])      w_y = 2'd3;
            else if (D[2]) w_y = 2'd2;
            else if (D[1]) w_y = 2'd1;
            else           w_y = 2'd0;
            w_v = |D;
            // Two or more lines set: some pair of lines is simultaneously high.
            w_m = (D[3] & (D[2] | D[1] | D[0])) |
                  (D[2] & (D[1] | D[0]))        |
                  (D[1] & D[0]);
        end
    end

    // Result register. On drain without accept the data fields hold their
    // last value; only out_valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y         <= 2'd0;
            r_v         <= 1'b0;
            r_m         <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_y         <= w_y;
            r_v         <= w_v;
            r_m         <= w_m;
            r_out_valid <= 1'b1;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    // Multi-hot event counter; clear has priority over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_accept && w_m && (r_err_count != c_CNT_MAX)) begin
            r_err_count <= r_err_count + c_CNT_ONE;
        end
    end

    assign Y         = r_y;
    assign V         = r_v;
    assign M         = r_m;
    assign out_valid = r_out_valid;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_encoder4to2_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder4to2_reg
//  Description : Self-checking bench for encoder4to2_reg. Two instances share
//                stimulus: one with the default counter width and one with a
//                2-bit counter so saturation is reachable quickly. Expected
//                results are queued when an item is accepted and compared
//                when the result appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder4to2_reg;

    typedef struct {
        logic [1:0] y;
        logic       v;
        logic       m;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       e;
    logic [3:0] d;
    logic       in_valid;
    logic       out_ready;
    logic       err_clr;

    logic       in_ready;
    logic [1:0] y;
    logic       v;
    logic       m;
    logic       out_valid;
    logic [7:0] err_count;

    logic       in_ready2;
    logic [1:0] y2;
    logic       v2;
    logic       m2;
    logic       out_valid2;
    logic [1:0] err_count2;

    exp_t       q[$];

    // Reference state
    logic       m_ov;
    logic [1:0] m_y;
    logic       m_v;
    logic       m_m;
    int         m_cnt8;
    int         m_cnt2;

    int         n_pass;
    int         n_fail;
    int         n_total;

    encoder4to2_reg #(.CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .E         (e),
        .D         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (y),
        .V         (v),
        .M         (m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    encoder4to2_reg #(.CNT_W(2)) u_dut_c2 (
        .clk       (clk),
        .rst       (rst),
        .E         (e),
        .D         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .Y         (y2),
        .V         (v2),
        .M         (m2),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_count (err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    function automatic exp_t model(input logic en, input logic [3:0] dd);
        exp_t r;
        r.y = 2'd0;
        r.v = 1'b0;
        r.m = 1'b0;
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (dd[i]) r.y = 2'(i);
            r.v = (dd != 4'd0);
            r.m = ($countones(dd) >= 2);
        end
        return r;
    endfunction

    // Reference 2-to-4 decoder for the round-trip check.
    function automatic logic [3:0] dec(input logic [1:0] yy, input logic en);
        return en ? (4'b0001 << yy) : 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid",  32'(out_valid),  32'(m_ov));
        chk("Y",          32'(y),          32'(m_y));
        chk("V",          32'(v),          32'(m_v));
        chk("M",          32'(m),          32'(m_m));
        chk("err_count",  32'(err_count),  32'(m_cnt8));
        chk("out_valid2", 32'(out_valid2), 32'(m_ov));
        chk("Y2",         32'(y2),         32'(m_y));
        chk("V2",         32'(v2),         32'(m_v));
        chk("M2",         32'(m2),         32'(m_m));
        chk("err_count2", 32'(err_count2), 32'(m_cnt2));
    endtask

    // One clock cycle: drive inputs, check in_ready, clock, check outputs.
    task automatic cycle(input logic ie, input logic [3:0] id, input logic iv,
                         input logic ordy, input logic clr);
        logic acc;
        exp_t x;
        e         = ie;
        d         = id;
        in_valid  = iv;
        out_ready = ordy;
        err_clr   = clr;
        #1;
        chk("in_ready",  32'(in_ready),  32'(!m_ov || ordy));
        chk("in_ready2", 32'(in_ready2), 32'(!m_ov || ordy));
        acc = iv && (!m_ov || ordy);
        x   = model(ie, id);
        if (acc) q.push_back(x);
        @(posedge clk);
        #1;
        if (clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (acc && x.m) begin
            if (m_cnt8 != 255) m_cnt8++;
            if (m_cnt2 != 3)   m_cnt2++;
        end
        if (acc) begin
            x    = q.pop_front();
            m_y  = x.y;
            m_v  = x.v;
            m_m  = x.m;
            m_ov = 1'b1;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        check_outputs();
    endtask

    task automatic model_reset();
        m_ov   = 1'b0;
        m_y    = 2'd0;
        m_v    = 1'b0;
        m_m    = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
        q.delete();
    endtask

    initial begin
        n_pass    = 0;
        n_fail    = 0;
        n_total   = 0;
        rst       = 1'b0;
        e         = 1'b0;
        d         = 4'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        model_reset();

        // Power-on reset
        #1 rst = 1'b1;
        #2;
        check_outputs();
        #9 rst = 1'b0;
        #1;
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // One-hot sweep with round trip through a 2-to-4 decode
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'b0001 << i, 1'b1, 1'b1, 1'b0);
            chk("roundtrip", 32'(dec(y, v)), 32'(4'b0001 << i));
        end

        // Priority / multi-hot / empty
        cycle(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 4'b1010, 1'b1, 1'b1, 1'b0);

        // Enable off: result delivered but all zero
        cycle(1'b0, 4'b1000, 1'b1, 1'b1, 1'b0);

        // Backpressure: one result then a 3-cycle stall with a new item offered
        cycle(1'b1, 4'b0101, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);   // drain + accept together
        cycle(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0);   // drain only, data holds

        // Counter saturation, then clear beating a multi-hot accept
        cycle(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 4'b0011, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 4'b1100, 1'b1, 1'b1, 1'b1);

        // Build up err_count=5, stall with a result held, reset mid-stall
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 4'b1001, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 4'b0111, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #2 rst = 1'b0;
        #1;
        chk("in_ready_after_midreset",  32'(in_ready),  32'd1);
        chk("in_ready2_after_midreset", 32'(in_ready2), 32'd1);

        // Normal operation after reset
        cycle(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
